frame_trigger_ctrl: RTL and testbench
=====================================

# frame_trigger_ctrl

Parametrised frame-start trigger generator for the CMOS capture path. Waits until the sensor command FIFO has drained and the SPI configuration engine reports idle, then issues a frame-start pulse of programmable width. It enforces a minimum gap between frames, counts issued frames, and optionally stops after a programmed frame count. It replaces the single-cycle, free-running frame trigger and drives the CMOS frame-request input and capture bookkeeping.

## Interface

Parameters:
- PULSE_W, 1, width of nframe_output pulse in clk cycles; legal range 1..255
- MIN_GAP, 16, idle cycles forced after each pulse before re-arming; legal range 0..65535
- CNT_W, 16, width of frame counter and frame_limit

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset; one clock, reset is synchronous and active-low
- enable  input  1  run enable; level-sensitive
- command_fifo_empty  input  1  sensor command FIFO empty
- spi_idle_fd  input  1  SPI engine idle
- frame_limit  input  CNT_W  frames to issue before stopping; 0 = unlimited
- nframe_output  output  1  frame-start pulse, active high
- frame_cnt  output  CNT_W  frames issued since last enable deassertion
- busy  output  1  high in ARMED, PULSE, GAP
- done  output  1  high in DONE

## Operation

- States: IDLE, ARMED, PULSE, GAP, DONE. State register is the only source of outputs; no combinational input-to-output paths.
- IDLE: if enable=1 and command_fifo_empty=1, go to ARMED; otherwise stay in IDLE.
- ARMED:
  - If enable=0, go to IDLE.
  - Else if command_fifo_empty=0, go back to IDLE. A new command was queued, so re-arming waits for the FIFO to drain.
  - Else if spi_idle_fd=1, go to PULSE and increment frame_cnt.
- PULSE: nframe_output=1. Stays for exactly PULSE_W cycles regardless of enable, so no runt pulses are produced.
- After PULSE: go to GAP if MIN_GAP>0; otherwise apply the end-of-frame decision below.
- GAP: lasts exactly MIN_GAP cycles, ignoring all inputs, then applies the end-of-frame decision.
- End-of-frame decision:
  - If enable=0, go to IDLE.
  - Else if frame_limit!=0 and frame_cnt>=frame_limit, go to DONE.
  - Else go to IDLE.
- DONE: done=1, no further pulses. When enable=0, go to IDLE.
- frame_cnt:
  - Clears to 0 on any cycle where enable=0 and state is IDLE, ARMED or DONE.
  - Wraps from 2^CNT_W-1 to 0 in unlimited mode.
  - Not cleared by reaching the limit.
- frame_limit is sampled only at the end-of-frame decision. Lowering it below frame_cnt mid-run therefore ends the run at the next decision.

## Timing

- Reset values: state IDLE, nframe_output=0, frame_cnt=0, busy=0, done=0. Reset in any state, including mid-pulse, takes effect on the next edge and truncates the pulse.
- ARMED with spi_idle_fd=1 at edge N:
  - nframe_output is high for cycles N+1..N+PULSE_W.
  - frame_cnt shows the new value from N+1.
- Minimum trigger period with inputs held ready is PULSE_W+MIN_GAP+2 cycles: 1 IDLE + 1 ARMED + PULSE_W + MIN_GAP.
- Latency from command_fifo_empty and spi_idle_fd both rising (from IDLE, enable=1) to nframe_output high is 2 cycles.
- busy is high from the first ARMED cycle through the last GAP cycle. It drops in the same cycle the state returns to IDLE or enters DONE.
- Simultaneous events:
  - enable falling in the same cycle that ARMED sees spi_idle_fd=1: enable wins, go to IDLE, no pulse.
  - command_fifo_empty falling in the same cycle as spi_idle_fd=1: no pulse.

## Test plan

- Basic pulse:
  - Stimulus: PULSE_W=3, MIN_GAP=4; enable=1, fifo empty, spi idle held.
  - Required: pulses of 3 cycles with period 9; frame_cnt counts 1,2,3...; busy low exactly 1 cycle per period.
- Frame limit:
  - Stimulus: frame_limit=2.
  - Required: exactly 2 pulses, then done=1, busy=0.
  - Stimulus: then enable=0 for 1 cycle, then enable=1.
  - Required: frame_cnt=0, done=0, pulsing resumes.
- Handshake gating:
  - Stimulus: command_fifo_empty toggles low during ARMED.
  - Required: returns to IDLE, no pulse.
  - Stimulus: spi_idle_fd held 0 for 50 cycles.
  - Required: stays ARMED, no pulse; pulse appears 1 cycle after spi_idle_fd rises.
- Enable drop during PULSE:
  - Stimulus: PULSE_W=5, enable=0 in second pulse cycle.
  - Required: full 5-cycle pulse, MIN_GAP honoured, then IDLE; frame_cnt clears in the first IDLE cycle.
- Wrap and reset:
  - Stimulus: CNT_W=4, unlimited mode, 17 frames.
  - Required: frame_cnt reads 1 after the 17th frame.
  - Stimulus: rst_n=0 mid-pulse.
  - Required: all outputs 0 on the next edge.
- MIN_GAP=0, PULSE_W=1:
  - Required: period 3 cycles, with no GAP state entered.

Source files
------------

// File: rtl/frame_trigger_ctrl.sv
// frame_trigger_ctrl: frame-start pulse generator gated on FIFO drain and SPI idle,
// with a minimum inter-frame gap, frame counting and an optional stop after N frames.
module frame_trigger_ctrl #(
    parameter int PULSE_W = 1,
    parameter int MIN_GAP = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             command_fifo_empty,
    input  logic             spi_idle_fd,
    input  logic [CNT_W-1:0] frame_limit,
    output logic             nframe_output,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, ARMED, PULSE, GAP, DONE} state_t;
    state_t state, state_nxt, eof_state;
    logic [15:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic last_pulse, last_gap;
    assign last_pulse = tmr == 16'(PULSE_W - 1);
    assign last_gap   = tmr == 16'(MIN_GAP - 1);
    // frame_limit only matters here, at the end of a frame
    assign eof_state  = (enable && frame_limit != '0 && frame_cnt >= frame_limit) ? DONE : IDLE;
    always_comb begin
        state_nxt = state;
        tmr_nxt   = '0;
        cnt_nxt   = (!enable && (state == IDLE || state == ARMED || state == DONE)) ? '0 : frame_cnt;
        case (state)
            IDLE:  state_nxt = (enable && command_fifo_empty) ? ARMED : IDLE;
            ARMED: begin
                if (!enable || !command_fifo_empty) state_nxt = IDLE;
                else if (spi_idle_fd) begin
                    state_nxt = PULSE;
                    cnt_nxt   = frame_cnt + CNT_W'(1);
                end
            end
            PULSE: begin
                tmr_nxt = last_pulse ? '0 : tmr + 16'd1;
                if (last_pulse) state_nxt = (MIN_GAP > 0) ? GAP : eof_state;
            end
            GAP: begin
                tmr_nxt = tmr + 16'd1;
                if (last_gap) state_nxt = eof_state;
            end
            DONE:    state_nxt = enable ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            frame_cnt <= cnt_nxt;
        end
    end
    assign nframe_output = state == PULSE;
    assign busy          = state == ARMED || state == PULSE || state == GAP;
    assign done          = state == DONE;
endmodule

// File: tb/tb_frame_trigger_ctrl.sv
// tb_frame_trigger_ctrl: three parameterisations driven in lockstep, checked per cycle
// against a countdown-based reference model through per-DUT scoreboards.
module tb_frame_trigger_ctrl;
    logic clk = 0, rst_n = 0, enable = 0, fe = 0, si = 0;
    logic [3:0] lim4 = 0;
    logic [5:0] lim6 = 0;
    logic na, ba, da, nb, bb, db, nc, bc, dc;
    logic [3:0] ca, cb;
    logic [5:0] cc;
    int total = 0, bad = 0;

    typedef struct {int pl; int gl; bit armed; bit dn; int cnt;} mdl_t;
    mdl_t ma, mb, mc;
    logic [10:0] qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    frame_trigger_ctrl #(.PULSE_W(3), .MIN_GAP(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .command_fifo_empty(fe), .spi_idle_fd(si),
        .frame_limit(lim4), .nframe_output(na), .frame_cnt(ca), .busy(ba), .done(da));
    frame_trigger_ctrl #(.PULSE_W(1), .MIN_GAP(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .command_fifo_empty(fe), .spi_idle_fd(si),
        .frame_limit(lim4), .nframe_output(nb), .frame_cnt(cb), .busy(bb), .done(db));
    frame_trigger_ctrl #(.PULSE_W(5), .MIN_GAP(2), .CNT_W(6)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .command_fifo_empty(fe), .spi_idle_fd(si),
        .frame_limit(lim6), .nframe_output(nc), .frame_cnt(cc), .busy(bc), .done(dc));

    // pl/gl = pulse/gap cycles still to show; a frame ends when both run out
    function automatic mdl_t step(mdl_t m, int pw, int mg, int w, bit en, bit f, bit s, int lim);
        bit decide = 0;
        if (!en && m.pl == 0 && m.gl == 0) m.cnt = 0;
        if (m.pl > 0) begin
            m.pl--;
            if (m.pl == 0) begin
                if (mg > 0) m.gl = mg;
                else decide = 1;
            end
        end else if (m.gl > 0) begin
            m.gl--;
            if (m.gl == 0) decide = 1;
        end else if (m.dn) begin
            if (!en) m.dn = 0;
        end else if (m.armed) begin
            if (!en || !f) m.armed = 0;
            else if (s) begin
                m.armed = 0;
                m.pl = pw;
                m.cnt = (m.cnt + 1) % (1 << w);
            end
        end else if (en && f) m.armed = 1;
        if (decide) m.dn = en && lim != 0 && m.cnt >= lim;
        return m;
    endfunction

    function automatic logic [10:0] pack(mdl_t m);
        logic [7:0] c = 8'(m.cnt);
        return {m.pl > 0, m.pl > 0 || m.gl > 0 || m.armed, m.dn, c};
    endfunction

    function automatic void chk(string name, logic [10:0] act, logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got nframe=%b busy=%b done=%b cnt=%0d want nframe=%b busy=%b done=%b cnt=%0d",
                     name, $time, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (qa.size() > 0) chk("cfg_a", {na, ba, da, 4'b0, ca}, qa.pop_front());
        if (qb.size() > 0) chk("cfg_b", {nb, bb, db, 4'b0, cb}, qb.pop_front());
        if (qc.size() > 0) chk("cfg_c", {nc, bc, dc, 2'b0, cc}, qc.pop_front());
    end

    task automatic drive(int n, bit r, bit e, bit f, bit s, int l, bit rnd);
        mdl_t z = '{default: 0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rnd) begin
                rst_n  = !($urandom_range(0, 299) == 0 || (ma.pl > 0 && $urandom_range(0, 39) == 0));
                enable = $urandom_range(0, 9) != 0;
                fe     = $urandom_range(0, 4) != 0;
                si     = 1'($urandom_range(0, 1));
                lim4   = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
                lim6   = 6'($urandom_range(0, 7));
            end else begin
                rst_n = !r; enable = e; fe = f; si = s; lim4 = 4'(l); lim6 = 6'(l);
            end
            ma = rst_n ? step(ma, 3, 4, 4, enable, fe, si, int'(lim4)) : z;
            mb = rst_n ? step(mb, 1, 0, 4, enable, fe, si, int'(lim4)) : z;
            mc = rst_n ? step(mc, 5, 2, 6, enable, fe, si, int'(lim6)) : z;
            qa.push_back(pack(ma));
            qb.push_back(pack(mb));
            qc.push_back(pack(mc));
        end
    endtask

    initial begin
        ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
        drive(3, 1, 0, 0, 0, 0, 0);
        drive(200, 0, 1, 1, 1, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        drive(60, 0, 1, 1, 1, 2, 0);
        drive(1, 0, 0, 1, 1, 2, 0);
        drive(30, 0, 1, 1, 1, 0, 0);
        drive(50, 0, 1, 1, 0, 0, 0);
        drive(20, 0, 1, 1, 1, 0, 0);
        drive(10, 0, 1, 0, 1, 0, 0);
        drive(3000, 0, 0, 0, 0, 0, 1);
        drive(2, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d want 0", qa.size() + qb.size() + qc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
